// File: rtl/mux_mode_sequencer_if.sv
// Purpose : bundles the button/auto/freeze/frame-strobe controls and the mode select outputs of the sequencer.
// Latency : none, wiring only.
// Backpressure: none; the outputs are level selects and one-cycle pulses with no ready.
// Ports   : master drives the controls and observes the selects; slave is the sequencer side.
interface mux_mode_sequencer_if;
    logic       btn_in;
    logic       auto_in;
    logic       freeze_in;
    logic       new_frame_in;
    logic       bg_out;
    logic       target_out;
    logic [1:0] mode_out;
    logic       pending_out;
    logic       mode_changed_out;

    modport master (
        output btn_in,
        output auto_in,
        output freeze_in,
        output new_frame_in,
        input  bg_out,
        input  target_out,
        input  mode_out,
        input  pending_out,
        input  mode_changed_out
    );

    modport slave (
        input  btn_in,
        input  auto_in,
        input  freeze_in,
        input  new_frame_in,
        output bg_out,
        output target_out,
        output mode_out,
        output pending_out,
        output mode_changed_out
    );
endinterface

// File: rtl/mux_mode_sequencer.sv
// Purpose : steps the pixel-mux display mode (camera / +crosshair / mask / +crosshair) on a debounced press or frame timer.
// Latency : button to pending ~2 sync + DEBOUNCE_CYCLES + 1 cycles; mode changes on the edge that samples new_frame_in.
// Backpressure: none; requests wait in a single coalescing pending bit until the next unfrozen frame boundary.
// Ports   : clk_in pixel clock, rst_in synchronous active-high reset, bus.slave carries the controls
//           (btn_in, auto_in, freeze_in, new_frame_in) and registered selects (bg_out, target_out, mode_out,
//           pending_out, mode_changed_out).
module mux_mode_sequencer #(
    parameter int DEBOUNCE_CYCLES = 742_500,
    parameter int AUTO_FRAMES     = 120
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    mux_mode_sequencer_if.slave  bus
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int FC_W = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(AUTO_FRAMES - 1);

    typedef enum logic [1:0] {
        MODE_CAMERA       = 2'b00,
        MODE_CAMERA_XHAIR = 2'b01,
        MODE_MASK         = 2'b10,
        MODE_MASK_XHAIR   = 2'b11
    } mode_t;

    logic            sync_a;
    logic            sync_b;
    logic            db_level;
    logic [DB_W-1:0] db_cnt;
    logic            press;
    logic [FC_W-1:0] frame_cnt;
    logic            pending;
    mode_t           mode_q;
    mode_t           mode_d;
    logic            changed_q;

    logic            frame_go;
    logic            auto_adv;
    logic            commit;

    // Button path: two-flop synchronizer, then a stability counter. The press
    // pulse is registered alongside the level flip so it appears in the first
    // cycle the debounced level reads high.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sync_a   <= 1'b0;
            sync_b   <= 1'b0;
            db_level <= 1'b0;
            db_cnt   <= '0;
            press    <= 1'b0;
        end else begin
            sync_a <= bus.btn_in;
            sync_b <= sync_a;
            press  <= 1'b0;
            if (sync_b == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_level <= sync_b;
                db_cnt   <= '0;
                press    <= sync_b;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    assign frame_go = bus.new_frame_in && !bus.freeze_in;
    assign auto_adv = frame_go && bus.auto_in && (frame_cnt == FC_LAST);
    // A press landing on the boundary cycle is folded into this commit rather
    // than parked in pending for the following frame.
    assign commit   = frame_go && (pending || press || auto_adv);

    // Frame timer: auto_in low forces zero, freeze holds the count so auto
    // cycling resumes where it left off.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            frame_cnt <= '0;
        end else if (!bus.auto_in) begin
            frame_cnt <= '0;
        end else if (frame_go) begin
            frame_cnt <= (frame_cnt == FC_LAST) ? '0 : frame_cnt + FC_W'(1);
        end
    end

    // Pending is cleared on every unfrozen boundary: either it was consumed by
    // the commit or it was already zero.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pending <= 1'b0;
        end else if (bus.freeze_in) begin
            pending <= 1'b0;
        end else if (bus.new_frame_in) begin
            pending <= 1'b0;
        end else if (press) begin
            pending <= 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            mode_q    <= MODE_CAMERA;
            changed_q <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            changed_q <= commit;
        end
    end

    always_comb begin
        mode_d = mode_q;
        if (commit) begin
            case (mode_q)
                MODE_CAMERA:       mode_d = MODE_CAMERA_XHAIR;
                MODE_CAMERA_XHAIR: mode_d = MODE_MASK;
                MODE_MASK:         mode_d = MODE_MASK_XHAIR;
                MODE_MASK_XHAIR:   mode_d = MODE_CAMERA;
                default:           mode_d = MODE_CAMERA;
            endcase
        end
    end

    assign bus.mode_out         = mode_q;
    assign bus.bg_out           = mode_q[1];
    assign bus.target_out       = mode_q[0];
    assign bus.pending_out      = pending;
    assign bus.mode_changed_out = changed_q;

endmodule

// File: tb/tb_mux_mode_sequencer.sv
// Purpose : self-checking bench for mux_mode_sequencer with short debounce/auto parameters.
// Latency : one check per clock, sampled on the falling edge.
// Backpressure: not applicable.
module tb_mux_mode_sequencer;

    localparam int DC = 4;
    localparam int AF = 3;

    logic clk_in = 1'b0;
    logic rst_in;

    mux_mode_sequencer_if bus ();

    mux_mode_sequencer #(
        .DEBOUNCE_CYCLES(DC),
        .AUTO_FRAMES(AF)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .bus(bus.slave)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    // Synced button = raw button two edges late; level flips after DC
    // consecutive synced samples disagreeing with it.
    logic       m_hist[$];
    logic       m_level;
    int         m_run;
    logic       m_press;
    logic       m_pend;
    logic       m_chg;
    int         m_fcnt;
    logic [1:0] m_mode;

    task automatic model_step(input logic r, input logic b, input logic a,
                              input logic f, input logic n);
        logic syn;
        logic new_press;
        logic auto_adv;
        logic commit;
        if (r) begin
            m_hist.delete();
            m_level = 1'b0;
            m_run   = 0;
            m_press = 1'b0;
            m_pend  = 1'b0;
            m_chg   = 1'b0;
            m_fcnt  = 0;
            m_mode  = 2'b00;
            return;
        end
        syn = (m_hist.size() >= 2) ? m_hist[m_hist.size() - 2] : 1'b0;
        m_hist.push_back(b);
        if (m_hist.size() > 2) void'(m_hist.pop_front());

        new_press = 1'b0;
        if (syn != m_level) m_run++;
        else                m_run = 0;
        if (m_run >= DC) begin
            m_level   = syn;
            m_run     = 0;
            new_press = syn;
        end

        auto_adv = n && a && !f && (m_fcnt == AF - 1);
        commit   = n && !f && (m_pend || m_press || auto_adv);

        if (!a)          m_fcnt = 0;
        else if (n && !f) m_fcnt = (m_fcnt + 1) % AF;

        if (f || n)       m_pend = 1'b0;
        else if (m_press) m_pend = 1'b1;

        if (commit) m_mode = m_mode + 2'd1;
        m_chg   = commit;
        m_press = new_press;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] outs();
        return {bus.bg_out, bus.target_out, bus.mode_out, bus.pending_out, bus.mode_changed_out};
    endfunction

    task automatic tick(input logic b, input logic a, input logic f, input logic n, input logic r);
        bus.btn_in       = b;
        bus.auto_in      = a;
        bus.freeze_in    = f;
        bus.new_frame_in = n;
        rst_in           = r;
        @(posedge clk_in);
        model_step(r, b, a, f, n);
        @(negedge clk_in);
        check("model", 32'(outs()), 32'({m_mode[1], m_mode[0], m_mode, m_pend, m_chg}));
    endtask

    logic btn_v, auto_v, frz_v;

    task automatic cyc(input logic n);
        tick(btn_v, auto_v, frz_v, n, 1'b0);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(1'b0);
    endtask

    // Full press: long enough to debounce high, then long enough to debounce low.
    task automatic press_btn();
        btn_v = 1'b1;
        idle(6);
        btn_v = 1'b0;
        idle(6);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       btn;
        logic       auto_en;
        logic       frz;
        logic       nf;
        logic [1:0] mode;
        logic       pend;
        logic       chg;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic b, input logic a, input logic f, input logic n,
                       input logic [1:0] m, input logic p, input logic c);
        vec_t v;
        v.btn = b; v.auto_en = a; v.frz = f; v.nf = n;
        v.mode = m; v.pend = p; v.chg = c;
        vecs.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected end by 1000000");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_auto[7] = '{0, 0, 1, 1, 1, 2, 2};
        btn_v = 1'b0; auto_v = 1'b0; frz_v = 1'b0;

        // Debounce glitch, full press, commit, release, idle boundary.
        for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 2'd0, 0, 0);
        for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 2'd0, 0, 0);
        for (int k = 0; k < 8; k++) add(1, 0, 0, 0, 2'd0, (k >= 6), 0);
        add(0, 0, 0, 1, 2'd1, 0, 1);
        for (int i = 0; i < 6; i++) add(0, 0, 0, 0, 2'd1, 0, 0);
        add(0, 0, 0, 1, 2'd1, 0, 0);
        add(0, 0, 0, 0, 2'd1, 0, 0);

        // Reset with the button held.
        tick(1, 0, 0, 0, 1);
        tick(1, 0, 0, 0, 1);
        check("reset_outputs", 32'(outs()), 32'd0);
        idle(2);
        check("reset_mode", 32'(bus.mode_out), 32'd0);

        foreach (vecs[i]) begin
            tick(vecs[i].btn, vecs[i].auto_en, vecs[i].frz, vecs[i].nf, 1'b0);
            check($sformatf("vec%0d", i),
                  32'({bus.mode_out, bus.pending_out, bus.mode_changed_out}),
                  32'({vecs[i].mode, vecs[i].pend, vecs[i].chg}));
        end

        // Coalesce three presses into one step, then wrap.
        press_btn(); press_btn(); press_btn();
        check("coalesce_pend", 32'(bus.pending_out), 32'd1);
        cyc(1'b1);
        check("coalesce_step", 32'({bus.mode_out, bus.mode_changed_out}), 32'({2'd2, 1'b1}));
        cyc(1'b0);
        check("changed_one_cycle", 32'({bus.mode_out, bus.mode_changed_out}), 32'({2'd2, 1'b0}));
        press_btn(); cyc(1'b1);
        check("step_to_3", 32'({bus.bg_out, bus.target_out}), 32'd3);
        press_btn(); cyc(1'b1);
        check("wrap", 32'(bus.mode_out), 32'd0);
        idle(1);

        // Auto cycling.
        auto_v = 1'b1;
        for (int p = 0; p < 7; p++) begin
            cyc(1'b1);
            check($sformatf("auto_pulse%0d", p + 1), 32'(bus.mode_out), 32'(exp_auto[p]));
            idle(2);
        end
        auto_v = 1'b0; idle(1); auto_v = 1'b1;
        cyc(1'b1); idle(1); cyc(1'b1);
        check("auto_clear", 32'(bus.mode_out), 32'd2);
        idle(1); cyc(1'b1);
        check("auto_after_clear", 32'(bus.mode_out), 32'd3);
        idle(1);

        // Pending and auto_adv on the same boundary give one step.
        cyc(1'b1); idle(1); cyc(1'b1);
        press_btn();
        check("pend_before_auto", 32'(bus.pending_out), 32'd1);
        cyc(1'b1);
        check("pend_plus_auto", 32'({bus.mode_out, bus.pending_out, bus.mode_changed_out}),
              32'({2'd0, 1'b0, 1'b1}));
        auto_v = 1'b0; idle(1);

        // Press pulse coinciding with the boundary.
        btn_v = 1'b1; idle(6);
        check("press_not_yet_pending", 32'(bus.pending_out), 32'd0);
        cyc(1'b1);
        check("press_same_cycle", 32'({bus.mode_out, bus.mode_changed_out}), 32'({2'd1, 1'b1}));
        cyc(1'b0);
        check("press_taken", 32'(bus.pending_out), 32'd0);
        btn_v = 1'b0; idle(6);

        // Freeze.
        auto_v = 1'b1; cyc(1'b1); idle(1);
        press_btn();
        check("freeze_pre_pend", 32'(bus.pending_out), 32'd1);
        frz_v = 1'b1; cyc(1'b0);
        check("freeze_clears_pend", 32'(bus.pending_out), 32'd0);
        press_btn(); cyc(1'b1); idle(1); cyc(1'b1);
        check("freeze_hold", 32'({bus.mode_out, bus.pending_out, bus.mode_changed_out}),
              32'({2'd1, 1'b0, 1'b0}));
        frz_v = 1'b0; idle(1); cyc(1'b1);
        check("resume_no_step", 32'(bus.mode_out), 32'd1);
        idle(1); cyc(1'b1);
        check("resume_step", 32'(bus.mode_out), 32'd2);
        auto_v = 1'b0; idle(1);

        // Reset mid-operation aborts a pending advance.
        press_btn();
        check("reset_mid_pend", 32'(bus.pending_out), 32'd1);
        tick(1, 0, 0, 0, 1);
        tick(1, 0, 0, 0, 1);
        check("reset_mid", 32'(outs()), 32'd0);
        idle(1); cyc(1'b1);
        check("reset_abort", 32'(bus.mode_out), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            logic n;
            logic r;
            if ($urandom_range(0, 9) == 0)  btn_v  = ~btn_v;
            if ($urandom_range(0, 39) == 0) auto_v = ~auto_v;
            if ($urandom_range(0, 49) == 0) frz_v  = ~frz_v;
            n = ($urandom_range(0, 5) == 0);
            r = ($urandom_range(0, 499) == 0);
            tick(btn_v, auto_v, frz_v, n, r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
